// File: rtl/eth_led_if.sv
// Per-port LED status bundle between the MAC-side status sources and the LED driver.
interface eth_led_if #(
   parameter int unsigned NUM_PORTS = 2
);
   logic [NUM_PORTS-1:0] link_up;
   logic [NUM_PORTS-1:0] fault;
   logic [NUM_PORTS-1:0] activity;
   logic [1:0]           led_mode;
   logic [NUM_PORTS-1:0] led_link;
   logic [NUM_PORTS-1:0] led_act;

   modport master (
      output link_up, fault, activity, led_mode,
      input  led_link, led_act
   );

   modport slave (
      input  link_up, fault, activity, led_mode,
      output led_link, led_act
   );
endinterface

// File: rtl/eth_led_controller.sv
// Per-port Ethernet link/activity LED driver with a visible activity blink,
// a shared fault flasher and global display modes.
module eth_led_controller #(
   parameter int unsigned NUM_PORTS   = 2,
   parameter int unsigned TICK_DIV    = 125000,
   parameter int unsigned BLINK_TICKS = 50,
   parameter int unsigned FAULT_TICKS = 250
) (
   input  logic     clk,
   input  logic     rst_n,
   eth_led_if.slave bus
);
   localparam int unsigned PRE_W = $clog2(TICK_DIV + 1);
   localparam int unsigned BLK_W = $clog2(BLINK_TICKS + 1);
   localparam int unsigned FLT_W = $clog2(FAULT_TICKS + 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BLINK_OFF = 2'd1,
      ST_BLINK_ON  = 2'd2
   } state_t;

   logic [PRE_W-1:0]     r_pre_cnt;
   logic                 w_tick;
   logic [FLT_W-1:0]     r_flash_cnt;
   logic                 r_flash_phase;

   state_t               r_state     [NUM_PORTS];
   state_t               w_state_nxt [NUM_PORTS];
   logic [BLK_W-1:0]     r_cnt       [NUM_PORTS];
   logic [BLK_W-1:0]     w_cnt_nxt   [NUM_PORTS];

   logic [NUM_PORTS-1:0] r_pending;
   logic [NUM_PORTS-1:0] w_pending_nxt;
   logic [NUM_PORTS-1:0] w_consume;
   logic [NUM_PORTS-1:0] w_blink_end;
   logic [NUM_PORTS-1:0] w_act_norm;
   logic [NUM_PORTS-1:0] r_led_link;
   logic [NUM_PORTS-1:0] r_led_act;
   logic [NUM_PORTS-1:0] w_led_link_nxt;
   logic [NUM_PORTS-1:0] w_led_act_nxt;

   logic [NUM_PORTS-1:0] w_link_up;
   logic [NUM_PORTS-1:0] w_fault;
   logic [NUM_PORTS-1:0] w_activity;
   logic [1:0]           w_led_mode;

   assign w_link_up    = bus.link_up;
   assign w_fault      = bus.fault;
   assign w_activity   = bus.activity;
   assign w_led_mode   = bus.led_mode;
   assign bus.led_link = r_led_link;
   assign bus.led_act  = r_led_act;

   // Time-base prescaler: one-cycle tick every TICK_DIV clocks
   assign w_tick = (r_pre_cnt == PRE_W'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre_cnt <= '0;
      end else if (w_tick) begin
         r_pre_cnt <= '0;
      end else begin
         r_pre_cnt <= r_pre_cnt + PRE_W'(1);
      end
   end

   // Shared fault flasher, phase toggles every FAULT_TICKS ticks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flash_cnt   <= '0;
         r_flash_phase <= 1'b0;
      end else if (w_tick) begin
         if (r_flash_cnt == FLT_W'(FAULT_TICKS - 1)) begin
            r_flash_cnt   <= '0;
            r_flash_phase <= ~r_flash_phase;
         end else begin
            r_flash_cnt   <= r_flash_cnt + FLT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
         end
         r_pending  <= '0;
         r_led_link <= '0;
         r_led_act  <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
         end
         r_pending  <= w_pending_nxt;
         r_led_link <= w_led_link_nxt;
         r_led_act  <= w_led_act_nxt;
      end
   end

   // Output is derived from the next state so an activity pulse shows 2 cycles later
   always_comb begin
      w_consume      = '0;
      w_blink_end    = '0;
      w_pending_nxt  = '0;
      w_act_norm     = '0;
      w_led_link_nxt = '0;
      w_led_act_nxt  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];
      end

      for (int i = 0; i < NUM_PORTS; i++) begin
         w_blink_end[i] = w_tick && (r_cnt[i] == BLK_W'(BLINK_TICKS - 1));
         case (r_state[i])
            ST_IDLE: begin
               if (r_pending[i]) begin
                  w_state_nxt[i] = ST_BLINK_OFF;
                  w_cnt_nxt[i]   = '0;
                  w_consume[i]   = 1'b1;
               end
            end
            ST_BLINK_OFF: begin
               if (w_blink_end[i]) begin
                  w_state_nxt[i] = ST_BLINK_ON;
                  w_cnt_nxt[i]   = '0;
               end else if (w_tick) begin
                  w_cnt_nxt[i]   = r_cnt[i] + BLK_W'(1);
               end
            end
            ST_BLINK_ON: begin
               if (w_blink_end[i]) begin
                  w_cnt_nxt[i] = '0;
                  if (r_pending[i]) begin
                     w_state_nxt[i] = ST_BLINK_OFF;
                     w_consume[i]   = 1'b1;
                  end else begin
                     w_state_nxt[i] = ST_IDLE;
                  end
               end else if (w_tick) begin
                  w_cnt_nxt[i] = r_cnt[i] + BLK_W'(1);
               end
            end
            default: begin
               w_state_nxt[i] = ST_IDLE;
               w_cnt_nxt[i]   = '0;
            end
         endcase

         // New activity wins over consumption in the same cycle
         w_pending_nxt[i] = (r_pending[i] & ~w_consume[i]) | w_activity[i];

         if (!w_link_up[i]) begin
            w_state_nxt[i]   = ST_IDLE;
            w_cnt_nxt[i]     = '0;
            w_pending_nxt[i] = 1'b0;
         end

         w_act_norm[i] = w_fault[i] ? r_flash_phase :
                         ((w_state_nxt[i] == ST_BLINK_OFF) ? 1'b0 : w_link_up[i]);
      end

      case (w_led_mode)
         2'd0: begin
            w_led_link_nxt = w_link_up;
            w_led_act_nxt  = w_act_norm;
         end
         2'd1: begin
            w_led_link_nxt = w_link_up;
            w_led_act_nxt  = w_link_up;
         end
         2'd2: begin
            w_led_link_nxt = '0;
            w_led_act_nxt  = '0;
         end
         default: begin
            w_led_link_nxt = '1;
            w_led_act_nxt  = '1;
         end
      endcase
   end
endmodule
